seg_scan_regfile: RTL and testbench

//  Parametrised multi-digit 7-segment register file with a built-in time-multiplexed scan driver.

---
 rtl/seg_scan_regfile.sv | 140 ++++++++++++++
 tb/tb_seg_scan_regfile.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_regfile.sv
// ---------------------------------------------------------------------------
// seg_scan_regfile
//   Multi-digit 7-segment register file with a built-in time-multiplexed scan
//   driver. Each of NUM_DIGITS entries holds {valid, dp, code[3:0]}. The scan
//   walks the entries one slot (SCAN_DIV clocks) at a time and drives a shared
//   active-low segment bus plus one active-low digit enable. The first clock of
//   every slot blanks all digits to avoid ghosting between neighbours.
//
// Ports
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   wr_en    write strobe
//   wr_addr  entry to write (addresses >= NUM_DIGITS are ignored)
//   wr_data  digit code
//   wr_dp    decimal point for the entry, 1 = lit
//   clear    synchronous clear of every valid flag (wins over a write)
//   rd_addr  readback address
//   rd_data  registered {valid, dp, code} of rd_addr, 0 when out of range
//   seg_n    segments, active low: [0]=a .. [6]=g, [7]=dp
//   dig_n    digit enables, active low, at most one low
// ---------------------------------------------------------------------------
module seg_scan_regfile #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 3,
  parameter int SCAN_DIV   = 1000,
  parameter int HEX_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  clear,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [5:0]            rd_data,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Entry layout: [5]=valid, [4]=dp, [3:0]=code
  logic [5:0]            entry [NUM_DIGITS];
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     idx;

  logic [5:0]            scan_entry;
  logic [5:0]            rd_entry;
  logic [NUM_DIGITS-1:0] dig_next;
  logic                  cnt_last;
  logic                  idx_last;

  function automatic logic [7:0] decode(input logic [5:0] e);
    logic [6:0] s;
    case (e[3:0])
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    // BCD builds blank the non-decimal codes instead of showing letters
    if (HEX_MODE == 0 && e[3:0] > 4'd9) s = 7'h7F;
    if (!e[5]) decode = 8'hFF;
    else       decode = {~e[4], s};
  endfunction

  assign cnt_last = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last = (idx == ADDR_W'(NUM_DIGITS - 1));

  // Address-compare muxes: unmatched (out-of-range) addresses fall out as 0.
  always_comb begin
    scan_entry = '0;
    rd_entry   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == ADDR_W'(i))     scan_entry = entry[i];
      if (rd_addr == ADDR_W'(i)) rd_entry   = entry[i];
    end
  end

  // Slot's first cycle (cnt==0) keeps every digit off as a ghost-blanking gap.
  always_comb begin
    dig_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_next[i] = !((cnt != '0) && (idx == ADDR_W'(i)));
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (clear)
          entry[i][5] <= 1'b0;   // dp and code survive a clear
        else if (wr_en && wr_addr == ADDR_W'(i))
          entry[i] <= {1'b1, wr_dp, wr_data};
      end
    end
  end

  // Scan counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      if (cnt_last) idx <= idx_last ? '0 : idx + ADDR_W'(1);
    end
  end

  // Output registers, all fed from pre-edge state. Readback therefore returns
  // the pre-write value on a same-address read-during-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n   <= 8'hFF;
      dig_n   <= '1;
      rd_data <= '0;
    end else begin
      seg_n   <= decode(scan_entry);
      dig_n   <= dig_next;
      rd_data <= rd_entry;
    end
  end

endmodule

// File: tb/tb_seg_scan_regfile.sv
module tb_seg_scan_regfile;

  localparam int N  = 8;
  localparam int AW = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          clear;
  logic [AW-1:0] rd_addr;
  logic [5:0]    rd_data, rd_data_h;
  logic [7:0]    seg_n, seg_n_h;
  logic [N-1:0]  dig_n, dig_n_h;

  always #5 clk = ~clk;

  seg_scan_regfile #(.NUM_DIGITS(N), .ADDR_W(AW), .SCAN_DIV(SD), .HEX_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .seg_n(seg_n), .dig_n(dig_n));

  seg_scan_regfile #(.NUM_DIGITS(N), .ADDR_W(AW), .SCAN_DIV(SD), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data_h),
    .seg_n(seg_n_h), .dig_n(dig_n_h));

  int total = 0;
  int bad   = 0;

  // Reference model: entry contents plus a count of clock edges since reset
  // release; the scan position follows from that count by plain arithmetic.
  logic [5:0] m_ent [16];
  logic [6:0] seg7  [16];
  int         edges;
  logic [7:0] exp_seg, exp_segh, exp_dig;
  logic [5:0] exp_rd;

  function automatic logic [7:0] dec(input logic [5:0] e, input bit hex);
    if (!e[5]) return 8'hFF;
    if (!hex && e[3:0] > 4'd9) return {~e[4], 7'h7F};
    return {~e[4], seg7[e[3:0]]};
  endfunction

  // Advance one clock: expectations come from the model state before the edge,
  // then the model absorbs this cycle's write/clear.
  task automatic tick();
    int c, x;
    c = edges % SD;
    x = (edges / SD) % N;
    exp_dig  = (c == 0) ? 8'hFF : ~(8'h01 << x);
    exp_seg  = dec(m_ent[x], 1'b0);
    exp_segh = dec(m_ent[x], 1'b1);
    exp_rd   = (rd_addr < N) ? m_ent[rd_addr] : 6'd0;
    @(posedge clk);
    edges++;
    if (clear) begin
      for (int i = 0; i < 16; i++) m_ent[i][5] = 1'b0;
    end else if (wr_en && wr_addr < N) begin
      m_ent[wr_addr] = {1'b1, wr_dp, wr_data};
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0; clear = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 16; i++) m_ent[i] = '0;
    wr_en = 1; wr_addr = 0; wr_data = 4'd5; wr_dp = 1;
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) tick();
    // Assert reset mid-cycle, mid-slot; outputs must clear without a clock.
    #3 rst_n = 1'b0;
    #1;
    total++; if (seg_n !== 8'hFF)   begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg_n); end
    total++; if (dig_n !== 8'hFF)   begin bad++; $display("FAIL reset_dig got=%h exp=ff", dig_n); end
    total++; if (rd_data !== 6'd0)  begin bad++; $display("FAIL reset_rd got=%h exp=00", rd_data); end
    total++; if (seg_n_h !== 8'hFF) begin bad++; $display("FAIL reset_seg_hex got=%h exp=ff", seg_n_h); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 16; i++) m_ent[i] = '0;
    tick();
    total++; if (dig_n !== 8'hFF) begin bad++; $display("FAIL reset_edge1_dig got=%h exp=ff", dig_n); end
    tick();
    total++; if (dig_n !== 8'hFE) begin bad++; $display("FAIL reset_edge2_dig got=%h exp=fe", dig_n); end
    total++; if (rd_data !== 6'd0) begin bad++; $display("FAIL reset_entry0 got=%h exp=00", rd_data); end
  endtask

  task automatic test_scan();
    logic [7:0] last_on;
    bit wrap_seen;
    last_on = 8'hFF;
    wrap_seen = 0;
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = 4'(i); wr_dp = 1'($urandom_range(0, 1));
      rd_addr = AW'(i);
      tick();
      total++; if (dig_n !== exp_dig) begin bad++; $display("FAIL scan_wr_dig i=%0d got=%h exp=%h", i, dig_n, exp_dig); end
      total++; if (seg_n !== exp_seg) begin bad++; $display("FAIL scan_wr_seg i=%0d got=%h exp=%h", i, seg_n, exp_seg); end
    end
    idle_inputs();
    for (int k = 0; k < 2 * N * SD + SD; k++) begin
      rd_addr = AW'(k % N);
      tick();
      total++; if (dig_n !== exp_dig)    begin bad++; $display("FAIL scan_dig k=%0d got=%h exp=%h", k, dig_n, exp_dig); end
      total++; if (seg_n !== exp_seg)    begin bad++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg_n, exp_seg); end
      total++; if (seg_n_h !== exp_segh) begin bad++; $display("FAIL scan_seg_hex k=%0d got=%h exp=%h", k, seg_n_h, exp_segh); end
      total++; if (rd_data !== exp_rd)   begin bad++; $display("FAIL scan_rd k=%0d got=%h exp=%h", k, rd_data, exp_rd); end
      if (dig_n != 8'hFF) begin
        if (last_on == 8'h7F && dig_n == 8'hFE) wrap_seen = 1;
        last_on = dig_n;
      end
    end
    total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL scan_wrap got=%0d exp=1", wrap_seen); end
  endtask

  task automatic test_hex();
    bit slot_seen;
    slot_seen = 0;
    wr_en = 1; wr_addr = 2; wr_data = 4'hC; wr_dp = 1;
    tick();
    idle_inputs();
    rd_addr = 2;
    tick();
    total++; if (rd_data !== 6'b11_1100) begin bad++; $display("FAIL hex_rd got=%b exp=111100", rd_data); end
    for (int k = 0; k < N * SD + 2; k++) begin
      tick();
      total++; if (seg_n !== exp_seg)    begin bad++; $display("FAIL hex_seg k=%0d got=%h exp=%h", k, seg_n, exp_seg); end
      total++; if (seg_n_h !== exp_segh) begin bad++; $display("FAIL hex_seg_hex k=%0d got=%h exp=%h", k, seg_n_h, exp_segh); end
      if (exp_dig == 8'hFB) begin
        slot_seen = 1;
        total++; if (seg_n !== 8'h7F)   begin bad++; $display("FAIL hex_slot2_bcd got=%h exp=7f", seg_n); end
        total++; if (seg_n_h !== 8'h46) begin bad++; $display("FAIL hex_slot2_hex got=%h exp=46", seg_n_h); end
        total++; if (dig_n !== 8'hFB)   begin bad++; $display("FAIL hex_slot2_dig got=%h exp=fb", dig_n); end
      end
    end
    total++; if (slot_seen !== 1'b1) begin bad++; $display("FAIL hex_slot2_reached got=%0d exp=1", slot_seen); end
  endtask

  task automatic test_clear_write();
    clear = 1; wr_en = 1; wr_addr = 5; wr_data = 4'd3; wr_dp = 1;
    tick();
    idle_inputs();
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      tick();
      if (a > 0) begin
        total++; if (rd_data[5] !== 1'b0) begin bad++; $display("FAIL clr_valid addr=%0d got=%b exp=0", a - 1, rd_data[5]); end
        total++; if (rd_data !== exp_rd)  begin bad++; $display("FAIL clr_rd addr=%0d got=%h exp=%h", a - 1, rd_data, exp_rd); end
      end
    end
    for (int k = 0; k < N * SD + 1; k++) begin
      tick();
      total++; if (seg_n !== 8'hFF) begin bad++; $display("FAIL clr_seg k=%0d got=%h exp=ff", k, seg_n); end
      total++; if (dig_n !== exp_dig) begin bad++; $display("FAIL clr_dig k=%0d got=%h exp=%h", k, dig_n, exp_dig); end
    end
  endtask

  task automatic test_bad_addr();
    wr_en = 1; wr_addr = 1; wr_data = 4'd4; wr_dp = 0;
    tick();
    wr_addr = 9; wr_data = 4'd8; wr_dp = 1;
    tick();
    idle_inputs();
    rd_addr = 9;
    tick();
    tick();
    total++; if (rd_data !== 6'd0) begin bad++; $display("FAIL bad_rd9 got=%h exp=00", rd_data); end
    for (int a = 0; a <= N; a++) begin
      rd_addr = AW'(a % N);
      tick();
      if (a > 0) begin
        total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL bad_entry addr=%0d got=%h exp=%h", a - 1, rd_data, exp_rd); end
      end
    end
  endtask

  task automatic test_rdw();
    wr_en = 1; wr_addr = 3; wr_data = 4'd1; wr_dp = 0;
    rd_addr = 3;
    tick();
    wr_data = 4'd7;
    tick();
    total++; if (rd_data !== 6'b10_0001) begin bad++; $display("FAIL rdw_old got=%b exp=100001", rd_data); end
    idle_inputs();
    tick();
    total++; if (rd_data !== 6'b10_0111) begin bad++; $display("FAIL rdw_new got=%b exp=100111", rd_data); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      clear   = ($urandom_range(0, 40) == 0);
      rd_addr = AW'($urandom_range(0, 15));
      tick();
      total++; if (dig_n !== exp_dig)    begin bad++; $display("FAIL rnd_dig k=%0d got=%h exp=%h", k, dig_n, exp_dig); end
      total++; if (seg_n !== exp_seg)    begin bad++; $display("FAIL rnd_seg k=%0d got=%h exp=%h", k, seg_n, exp_seg); end
      total++; if (seg_n_h !== exp_segh) begin bad++; $display("FAIL rnd_seg_hex k=%0d got=%h exp=%h", k, seg_n_h, exp_segh); end
      total++; if (rd_data !== exp_rd)   begin bad++; $display("FAIL rnd_rd k=%0d got=%h exp=%h", k, rd_data, exp_rd); end
    end
    idle_inputs();
  endtask

  initial begin
    seg7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++) m_ent[i] = '0;
    edges = 0;
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = 0;
    test_reset();
    $display("test_reset complete total=%0d bad=%0d", total, bad);
    test_scan();
    $display("test_scan complete total=%0d bad=%0d", total, bad);
    test_hex();
    $display("test_hex complete total=%0d bad=%0d", total, bad);
    test_clear_write();
    $display("test_clear_write complete total=%0d bad=%0d", total, bad);
    test_bad_addr();
    $display("test_bad_addr complete total=%0d bad=%0d", total, bad);
    test_rdw();
    $display("test_rdw complete total=%0d bad=%0d", total, bad);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
